game_controller: RTL
====================

GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 SHALL have parameter BIRD_X, default 200, meaning fixed bird left edge in pixels.
REQ-002 SHALL have parameter BIRD_SIZE, default 20, meaning bird width and height in pixels.
REQ-003 SHALL have parameter PIPE_W, default 40, meaning pipe width in pixels.
REQ-004 SHALL have parameter GAP_H, default 120, meaning vertical gap height in pixels.
REQ-005 SHALL have parameter FLOOR_Y, default 480, meaning floor line in pixels.
REQ-006 SHALL have parameter DEAD_HOLD, default 256, meaning lockout length in gameClk cycles.
REQ-007 SHALL have port gameClk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port button, input, 1 bit: one-cycle click pulse.
REQ-010 SHALL have port bird_y, input, 11 bits: bird top edge.
REQ-011 SHALL have ports pipe1_x, pipe1_y, pipe2_x, pipe2_y, input, 11 bits each: pipe left edge and gap top edge.
REQ-012 SHALL have port passColumn, input, 1 bit: one-cycle pulse when a column is passed.
REQ-013 SHALL have port state, output, 2 bits: IDLE=0, PLAY=1, DEAD=2; value 3 never produced.
REQ-014 SHALL have port finished, output, 1 bit: high whenever state != PLAY.
REQ-015 SHALL have port round_start, output, 1 bit: one-cycle pulse on IDLE->PLAY.
REQ-016 SHALL have port score_bcd, output, 16 bits: four BCD digits, current score.
REQ-017 SHALL have port high_bcd, output, 16 bits: four BCD digits, best score.

Function
REQ-018 SHALL define hit_x(i) as (BIRD_X < pipe_i_x+PIPE_W) AND (pipe_i_x < BIRD_X+BIRD_SIZE), with all sums in 12 bits (no wrap).
REQ-019 SHALL define hit(i) as hit_x(i) AND (bird_y < pipe_i_y OR bird_y+BIRD_SIZE > pipe_i_y+GAP_H).
REQ-020 SHALL define collide as hit(1) OR hit(2) OR (bird_y+BIRD_SIZE > FLOOR_Y), evaluated combinationally from current inputs.
REQ-021 SHALL, in IDLE with button=1, go to PLAY next cycle, clear score_bcd to 0, and pulse round_start for exactly that cycle.
REQ-022 SHALL, in IDLE with button=0, stay in IDLE; passColumn and collide are ignored.
REQ-023 SHALL, in PLAY with collide=1, go to DEAD next cycle (one-cycle latency), load the hold counter with DEAD_HOLD-1, and ignore button.
REQ-024 SHALL, in PLAY with passColumn=1, increment score_bcd by 1 in BCD (digit carry 9->0), saturating at 9999.
REQ-025 SHALL, on simultaneous passColumn and collide in PLAY, apply both: score increments and state goes to DEAD.
REQ-026 SHALL, in the first DEAD cycle, set high_bcd to score_bcd if score_bcd > high_bcd (BCD compare equals numeric compare).
REQ-027 SHALL, in DEAD, decrement the hold counter each cycle down to 0; button is ignored while the counter is nonzero.
REQ-028 SHALL, in DEAD with counter=0 and button=1, go to IDLE; score_bcd is held until the next round_start.
REQ-029 SHALL ignore passColumn outside PLAY.
REQ-030 SHALL register all outputs; finished is decoded from the state register.

Reset
REQ-031 SHALL, on reset=1 at a clock edge, set state=IDLE, finished=1, round_start=0, score_bcd=0, high_bcd=0, and hold counter=0.
REQ-032 SHALL give reset priority over every other input, including mid-PLAY and mid-DEAD; high_bcd is cleared only by reset.

Verification
REQ-033 SHALL cover: reset, then button pulse -> state=1, finished=0, round_start high exactly one cycle, score_bcd=0x0000.
REQ-034 SHALL cover: in PLAY, 10 passColumn pulses with no collision -> score_bcd=0x0010; then bird_y=470 (floor hit) -> state=2 one cycle later, high_bcd=0x0010.
REQ-035 SHALL cover: pipe1_x=190, pipe1_y=100, bird_y=90 -> collide; bird_y=150 -> no collide; pipe1_x=240 -> no x-overlap.
REQ-036 SHALL cover: DEAD entered, button pulsed at cycle 100 -> stays DEAD; button pulsed at cycle 256 or later -> IDLE next cycle.
REQ-037 SHALL cover: score preset to 9999 via 9999 passes -> further passColumn leaves 0x9999; passColumn and collide in the same cycle -> increments and goes to DEAD.
REQ-038 SHALL cover: reset asserted mid-PLAY with score 0x0005 and high_bcd 0x0003 -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/game_controller.sv
// game_controller: flappy-style round FSM with collision detect, BCD score and high score
module game_controller #(
  parameter int BIRD_X    = 200,
  parameter int BIRD_SIZE = 20,
  parameter int PIPE_W    = 40,
  parameter int GAP_H     = 120,
  parameter int FLOOR_Y   = 480,
  parameter int DEAD_HOLD = 256
) (
  input  logic        gameClk,
  input  logic        reset,
  input  logic        button,
  input  logic [10:0] bird_y,
  input  logic [10:0] pipe1_x,
  input  logic [10:0] pipe1_y,
  input  logic [10:0] pipe2_x,
  input  logic [10:0] pipe2_y,
  input  logic        passColumn,
  output logic [1:0]  state,
  output logic        finished,
  output logic        round_start,
  output logic [15:0] score_bcd,
  output logic [15:0] high_bcd
);
  localparam int HW = $clog2(DEAD_HOLD + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DEAD = 2'd2} st_t;
  st_t st, st_n;
  logic [HW-1:0] hold, hold_n;
  logic [15:0] score_n, high_n;
  logic rs_n, collide;
  function automatic logic hit(input logic [10:0] px, input logic [10:0] py, input logic [10:0] by);
    logic [11:0] x, y, b;
    x = {1'b0, px};
    y = {1'b0, py};
    b = {1'b0, by};
    return (12'(BIRD_X) < x + 12'(PIPE_W)) && (x < 12'(BIRD_X + BIRD_SIZE)) &&
           ((b < y) || (b + 12'(BIRD_SIZE) > y + 12'(GAP_H)));
  endfunction
  function automatic logic [15:0] bcd_inc(input logic [15:0] s);
    logic [15:0] r;
    logic c;
    r = s;
    c = 1'b1;
    if (s == 16'h9999) return s;
    for (int i = 0; i < 4; i++)
      if (c) begin
        r[4*i+:4] = (s[4*i+:4] == 4'd9) ? 4'd0 : s[4*i+:4] + 4'd1;
        c = (s[4*i+:4] == 4'd9);
      end
    return r;
  endfunction
  assign collide = hit(pipe1_x, pipe1_y, bird_y) || hit(pipe2_x, pipe2_y, bird_y) ||
                   ({1'b0, bird_y} + 12'(BIRD_SIZE) > 12'(FLOOR_Y));
  assign state = st;
  assign finished = (st != PLAY);
  always_comb begin
    st_n = st;
    hold_n = hold;
    score_n = score_bcd;
    high_n = high_bcd;
    rs_n = 1'b0;
    case (st)
      IDLE: if (button) begin
        st_n = PLAY;
        score_n = '0;
        rs_n = 1'b1;
      end
      PLAY: begin
        if (passColumn) score_n = bcd_inc(score_bcd);
        if (collide) begin
          st_n = DEAD;
          hold_n = HW'(DEAD_HOLD - 1);
        end
      end
      DEAD: begin
        // score is frozen in DEAD, so comparing every cycle equals comparing once on entry
        if (score_bcd > high_bcd) high_n = score_bcd;
        if (hold != '0) hold_n = hold - HW'(1);
        else if (button) st_n = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge gameClk) begin
    if (reset) begin
      st <= IDLE;
      hold <= '0;
      round_start <= 1'b0;
      score_bcd <= '0;
      high_bcd <= '0;
    end else begin
      st <= st_n;
      hold <= hold_n;
      round_start <= rs_n;
      score_bcd <= score_n;
      high_bcd <= high_n;
    end
  end
endmodule
